spram_access_arbiter: RTL and testbench

//  Shares the 64x8 single-port FPGA RAM between two requesters: the HPS bridge (host_*) and the annealer

---
 rtl/spram_access_arbiter_pkg.sv | 25 ++
 rtl/spram_access_arbiter_if.sv | 24 ++
 rtl/spram_access_arbiter_pick.sv | 42 ++++
 rtl/spram_access_arbiter.sv | 147 ++++++++++++++
 tb/tb_spram_access_arbiter.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spram_access_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spram_arb_pkg
// Brief   : Shared types and default sizes for the single-port RAM arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package spram_arb_pkg;

  localparam int c_def_aw     = 6;
  localparam int c_def_dw     = 8;
  localparam int c_def_rd_lat = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } state_e;

  typedef enum logic {
    OWN_HOST = 1'b0,
    OWN_ANL  = 1'b1
  } owner_e;

endpackage
`default_nettype wire

// File: rtl/spram_access_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : spram_access_arbiter_if
// Brief   : One requester port of the RAM arbiter (request, grant, read return).
// Revision: 1.0 - initial release
// ============================================================================
interface spram_access_arbiter_if #(
  parameter int AW = spram_arb_pkg::c_def_aw,
  parameter int DW = spram_arb_pkg::c_def_dw
) ();

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input  gnt, rvalid, rdata);
  modport slave  (input  req, we, addr, wdata, output gnt, rvalid, rdata);

endinterface
`default_nettype wire

// File: rtl/spram_access_arbiter_pick.sv
`default_nettype none
// ============================================================================
// Module  : spram_arb_pick
// Brief   : Combinational winner select; SPRAM_ARB_RR_EN selects round-robin,
//           otherwise the annealer has fixed priority.
// Revision: 1.0 - initial release
// ============================================================================
module spram_arb_pick
  import spram_arb_pkg::*;
(
  input  logic   host_req,
  input  logic   anl_req,
  input  owner_e fav,
  output logic   any_req,
  output owner_e winner,
  output owner_e fav_nxt
);

  assign any_req = host_req | anl_req;

`ifdef SPRAM_ARB_RR_EN
  logic contested;

  // fav names the port that wins the next tie; it moves to the loser.
  always_comb begin
    contested = host_req & anl_req;
    winner    = anl_req ? OWN_ANL : OWN_HOST;
    fav_nxt   = fav;
    if (contested) begin
      winner  = fav;
      fav_nxt = (fav == OWN_HOST) ? OWN_ANL : OWN_HOST;
    end
  end
`else
  always_comb begin
    winner  = anl_req ? OWN_ANL : OWN_HOST;
    fav_nxt = fav;
  end
`endif

endmodule
`default_nettype wire

// File: rtl/spram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : spram_access_arbiter
// Brief   : Serialises host and annealer accesses onto one registered 64x8
//           single-port RAM; SPRAM_ARB_RR_EN enables round-robin ties.
// Revision: 1.0 - initial release
// ============================================================================
module spram_access_arbiter
  import spram_arb_pkg::*;
#(
  parameter int AW     = c_def_aw,
  parameter int DW     = c_def_dw,
  parameter int RD_LAT = c_def_rd_lat
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spram_access_arbiter_if.slave host,
  spram_access_arbiter_if.slave anl,
  output logic [AW-1:0]         ram_addr,
  output logic                  ram_we,
  output logic [DW-1:0]         ram_data,
  input  logic [DW-1:0]         ram_q,
  output logic                  busy
);

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  owner_e        fav_q, fav_d;
  logic [1:0]    lat_cnt_q, lat_cnt_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_data_q, ram_data_d;
  logic          ram_we_q, ram_we_d;
  logic          host_gnt_q, host_gnt_d, anl_gnt_q, anl_gnt_d;
  logic          host_rvalid_q, host_rvalid_d, anl_rvalid_q, anl_rvalid_d;
  logic [DW-1:0] host_rdata_q, host_rdata_d, anl_rdata_q, anl_rdata_d;

  logic   any_req;
  owner_e winner, fav_nxt;

  spram_arb_pick u_pick (
    .host_req (host.req),
    .anl_req  (anl.req),
    .fav      (fav_q),
    .any_req  (any_req),
    .winner   (winner),
    .fav_nxt  (fav_nxt)
  );

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    fav_d         = fav_q;
    lat_cnt_d     = lat_cnt_q;
    ram_addr_d    = ram_addr_q;
    ram_data_d    = ram_data_q;
    ram_we_d      = 1'b0;
    host_gnt_d    = 1'b0;
    anl_gnt_d     = 1'b0;
    host_rvalid_d = 1'b0;
    anl_rvalid_d  = 1'b0;
    host_rdata_d  = host_rdata_q;
    anl_rdata_d   = anl_rdata_q;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d    = winner;
          fav_d      = fav_nxt;
          ram_addr_d = (winner == OWN_ANL) ? anl.addr  : host.addr;
          ram_data_d = (winner == OWN_ANL) ? anl.wdata : host.wdata;
          ram_we_d   = (winner == OWN_ANL) ? anl.we    : host.we;
          host_gnt_d = (winner == OWN_HOST);
          anl_gnt_d  = (winner == OWN_ANL);
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (ram_we_q) begin
          state_d = IDLE;
        end else begin
          lat_cnt_d = 2'(RD_LAT - 1);
          state_d   = RDWAIT;
        end
      end
      RDWAIT: begin
        if (lat_cnt_q == 2'd0) begin
          if (owner_q == OWN_ANL) begin
            anl_rvalid_d = 1'b1;
            anl_rdata_d  = ram_q;
          end else begin
            host_rvalid_d = 1'b1;
            host_rdata_d  = ram_q;
          end
          state_d = IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      owner_q       <= OWN_HOST;
      fav_q         <= OWN_HOST;
      lat_cnt_q     <= 2'd0;
      ram_addr_q    <= '0;
      ram_data_q    <= '0;
      ram_we_q      <= 1'b0;
      host_gnt_q    <= 1'b0;
      anl_gnt_q     <= 1'b0;
      host_rvalid_q <= 1'b0;
      anl_rvalid_q  <= 1'b0;
      host_rdata_q  <= '0;
      anl_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      fav_q         <= fav_d;
      lat_cnt_q     <= lat_cnt_d;
      ram_addr_q    <= ram_addr_d;
      ram_data_q    <= ram_data_d;
      ram_we_q      <= ram_we_d;
      host_gnt_q    <= host_gnt_d;
      anl_gnt_q     <= anl_gnt_d;
      host_rvalid_q <= host_rvalid_d;
      anl_rvalid_q  <= anl_rvalid_d;
      host_rdata_q  <= host_rdata_d;
      anl_rdata_q   <= anl_rdata_d;
    end
  end

  assign ram_addr    = ram_addr_q;
  assign ram_data    = ram_data_q;
  assign ram_we      = ram_we_q;
  assign busy        = (state_q != IDLE);
  assign host.gnt    = host_gnt_q;
  assign host.rvalid = host_rvalid_q;
  assign host.rdata  = host_rdata_q;
  assign anl.gnt     = anl_gnt_q;
  assign anl.rvalid  = anl_rvalid_q;
  assign anl.rdata   = anl_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_spram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_spram_access_arbiter
// Brief   : Directed bench with a cycle-scheduled transaction model of the
//           arbiter and a registered-address RAM (RD_LAT = 1).
// Revision: 1.0 - initial release
// ============================================================================
module tb_spram_access_arbiter;

  localparam int AW     = 6;
  localparam int DW     = 8;
  localparam int RD_LAT = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] ram_q;
  logic          busy;
  int            cyc = 0;

  spram_access_arbiter_if #(.AW(AW), .DW(DW)) hif ();
  spram_access_arbiter_if #(.AW(AW), .DW(DW)) aif ();

  spram_access_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .host     (hif),
    .anl      (aif),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_data (ram_data),
    .ram_q    (ram_q),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-port RAM with registered address, one cycle to q.
  logic [DW-1:0] ram_mem [64];
  logic [AW-1:0] ram_addr_r;
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_data;
    ram_addr_r <= ram_addr;
  end
  assign ram_q = ram_mem[ram_addr_r];

  logic [35:0] dut_vec;
  assign dut_vec = {busy, hif.gnt, hif.rvalid, hif.rdata, aif.gnt, aif.rvalid, aif.rdata,
                    ram_we, ram_addr, ram_data};

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] pat(input int a);
    return 8'(a * 7 + 3);
  endfunction

  // Future events per cycle, produced when the model accepts a request.
  typedef struct packed {
    logic       hg, ag, upd, we, hrv, arv;
    logic [5:0] addr;
    logic [7:0] data;
    logic [7:0] rdata;
  } ev_t;

  ev_t         sch [8];
  ev_t         ev;
  logic [7:0]  mdl_mem [64];
  logic [7:0]  m_hrd, m_ard, m_rdata;
  logic [5:0]  m_raddr;
  int          m_free;
  logic        m_wa, m_we;
  logic [5:0]  m_ad;
  logic [7:0]  m_wd;
  logic [35:0] exp_vec;
`ifdef SPRAM_ARB_RR_EN
  logic        m_fav_anl;
`endif

  // Observations used by the directed checks.
  int          hg_cnt = 0, ag_cnt = 0, hrv_cnt = 0, arv_cnt = 0, we_cnt = 0, gcnt = 0;
  int          hrv_cyc = 0;
  logic [5:0]  we_addr = '0;
  logic [15:0] gord = '0;

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic req_access(input bit is_anl, input bit we, input logic [5:0] addr,
                            input logic [7:0] wd);
    bit got;
    got = 1'b0;
    if (is_anl) begin aif.req = 1'b1; aif.we = we; aif.addr = addr; aif.wdata = wd; end
    else        begin hif.req = 1'b1; hif.we = we; hif.addr = addr; hif.wdata = wd; end
    for (int n = 0; n < 200 && !got; n++) begin
      @(posedge clk);
      #1;
      got = is_anl ? aif.gnt : hif.gnt;
    end
    if (is_anl) aif.req = 1'b0;
    else        hif.req = 1'b0;
    check(is_anl ? "anl_grant_arrives" : "host_grant_arrives", 64'(got), 64'd1);
  endtask

  int t0, t1, we0, hrv0, arv0, hg0, gc0;

  initial begin
    hif.req = 1'b0; hif.we = 1'b0; hif.addr = '0; hif.wdata = '0;
    aif.req = 1'b0; aif.we = 1'b0; aif.addr = '0; aif.wdata = '0;

    fork
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          for (int i = 0; i < 8; i++) sch[i] = '0;
          m_hrd = '0; m_ard = '0; m_raddr = '0; m_rdata = '0;
          m_free = cyc + 1;
`ifdef SPRAM_ARB_RR_EN
          m_fav_anl = 1'b0;
`endif
          check("outputs_in_reset", 64'(dut_vec), 64'd0);
        end else begin
          ev = sch[cyc % 8];
          sch[cyc % 8] = '0;
          if (ev.upd) begin m_raddr = ev.addr; m_rdata = ev.data; end
          if (ev.hrv) m_hrd = ev.rdata;
          if (ev.arv) m_ard = ev.rdata;
          exp_vec = {(cyc < m_free), ev.hg, ev.hrv, m_hrd, ev.ag, ev.arv, m_ard,
                     ev.upd & ev.we, m_raddr, m_rdata};
          check("cycle_outputs", 64'(dut_vec), 64'(exp_vec));
          if (cyc >= m_free && (hif.req || aif.req)) begin
            if (hif.req && aif.req) begin
`ifdef SPRAM_ARB_RR_EN
              m_wa = m_fav_anl;
              m_fav_anl = !m_wa;
`else
              m_wa = 1'b1;
`endif
            end else begin
              m_wa = aif.req;
            end
            m_we = m_wa ? aif.we : hif.we;
            m_ad = m_wa ? aif.addr : hif.addr;
            m_wd = m_wa ? aif.wdata : hif.wdata;
            sch[(cyc + 1) % 8].hg   = !m_wa;
            sch[(cyc + 1) % 8].ag   = m_wa;
            sch[(cyc + 1) % 8].upd  = 1'b1;
            sch[(cyc + 1) % 8].we   = m_we;
            sch[(cyc + 1) % 8].addr = m_ad;
            sch[(cyc + 1) % 8].data = m_wd;
            if (m_we) begin
              mdl_mem[m_ad] = m_wd;
              m_free = cyc + 2;
            end else begin
              sch[(cyc + 2 + RD_LAT) % 8].hrv   = !m_wa;
              sch[(cyc + 2 + RD_LAT) % 8].arv   = m_wa;
              sch[(cyc + 2 + RD_LAT) % 8].rdata = mdl_mem[m_ad];
              m_free = cyc + 2 + RD_LAT;
            end
          end
        end
        if (hif.gnt)    begin hg_cnt++; gcnt++; gord = {gord[14:0], 1'b0}; end
        if (aif.gnt)    begin ag_cnt++; gcnt++; gord = {gord[14:0], 1'b1}; end
        if (hif.rvalid) begin hrv_cnt++; hrv_cyc = cyc; end
        if (aif.rvalid) arv_cnt++;
        if (ram_we)     begin we_cnt++; we_addr = ram_addr; end
      end
    join_none

    idle(3);
    rst_n = 1'b1;
    check("post_reset_outputs", 64'(dut_vec), 64'd0);

    // Host write then read of 0x12.
    we0 = we_cnt;
    req_access(1'b0, 1'b1, 6'h12, 8'hA5);
    idle(2);
    t0 = cyc;
    req_access(1'b0, 1'b0, 6'h12, 8'h00);
    idle(3);
    check("t1_we_pulses", 64'(we_cnt - we0), 64'd1);
    check("t1_we_addr", 64'(we_addr), 64'h12);
    check("t1_rvalid_latency", 64'(hrv_cyc - t0), 64'd3);
    check("t1_host_rdata", 64'(hif.rdata), 64'hA5);

    // Simultaneous reads after preloading 0x01/0x02.
    req_access(1'b1, 1'b1, 6'h01, 8'h11);
    req_access(1'b1, 1'b1, 6'h02, 8'h22);
    idle(2);
    gc0 = gcnt; hrv0 = hrv_cnt; arv0 = arv_cnt;
    fork
      req_access(1'b0, 1'b0, 6'h01, 8'h00);
      req_access(1'b1, 1'b0, 6'h02, 8'h00);
    join
    idle(3);
    check("t2_grant_count", 64'(gcnt - gc0), 64'd2);
`ifdef SPRAM_ARB_RR_EN
    check("t2_grant_order", 64'(gord[1:0]), 64'b01);
`else
    check("t2_grant_order", 64'(gord[1:0]), 64'b10);
`endif
    check("t2_anl_rdata", 64'(aif.rdata), 64'h22);
    check("t2_host_rdata", 64'(hif.rdata), 64'h11);
    check("t2_rvalid_counts", 64'({hrv_cnt - hrv0, arv_cnt - arv0}), {32'd1, 32'd1});

    // Six accesses with both requests held.
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    gc0 = gcnt;
    hif.req = 1'b1; hif.we = 1'b0; hif.addr = 6'h01;
    aif.req = 1'b1; aif.we = 1'b0; aif.addr = 6'h02;
    for (int k = 0; k < 60 && (gcnt - gc0) < 6; k++) idle(1);
    hif.req = 1'b0; aif.req = 1'b0;
    idle(4);
    check("t3_grant_count", 64'(gcnt - gc0), 64'd6);
`ifdef SPRAM_ARB_RR_EN
    check("t3_grant_order", 64'(gord[5:0]), 64'b010101);
`else
    check("t3_grant_order", 64'(gord[5:0]), 64'b111111);
`endif

    // Back-to-back annealer writes over the whole address space, then readback.
    we0 = we_cnt;
    for (int a = 0; a < 64; a++) begin
      req_access(1'b1, 1'b1, 6'(a), pat(a));
      if (a == 0) t0 = cyc;
    end
    t1 = cyc;
    idle(2);
    check("t5_we_pulses", 64'(we_cnt - we0), 64'd64);
    check("t5_we_span", 64'(t1 - t0), 64'd126);
    hrv0 = hrv_cnt;
    for (int a = 0; a < 64; a++) req_access(1'b0, 1'b0, 6'(a), 8'h00);
    idle(3);
    check("t5_readbacks", 64'(hrv_cnt - hrv0), 64'd64);
    check("t5_last_rdata", 64'(hif.rdata), 64'(pat(63)));

    // Reset while a host read is in RDWAIT.
    hrv0 = hrv_cnt;
    req_access(1'b0, 1'b0, 6'h05, 8'h00);
    idle(1);
    rst_n = 1'b0;
    #1;
    check("t4_outputs_in_reset", 64'(dut_vec), 64'd0);
    idle(2);
    rst_n = 1'b1;
    idle(3);
    check("t4_no_rvalid", 64'(hrv_cnt - hrv0), 64'd0);
    req_access(1'b0, 1'b0, 6'h3F, 8'h00);
    idle(3);
    check("t4_read_after_reset", 64'(hif.rdata), 64'(pat(63)));

    // Host request withdrawn while the annealer holds the RAM.
    hg0 = hg_cnt; we0 = we_cnt;
    req_access(1'b1, 1'b0, 6'h02, 8'h00);
    hif.req = 1'b1; hif.we = 1'b1; hif.addr = 6'h10; hif.wdata = 8'hEE;
    idle(1);
    hif.req = 1'b0;
    idle(5);
    check("t6_no_host_gnt", 64'(hg_cnt - hg0), 64'd0);
    check("t6_no_ram_write", 64'(we_cnt - we0), 64'd0);
    check("t6_anl_rdata", 64'(aif.rdata), 64'(pat(2)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
